guess_game_ctrl: RTL
====================

GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_BASE, default 25000000, FSM step period in clk cycles at level 0; legal range >=128.
REQ-002 SHALL have parameter RESULT_HOLD, default 4, result display time in ticks; legal range >=1.
REQ-003 SHALL have parameter MAX_MISSES, default 3, losses that end the game; legal range 1..15.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable cycles required per button; used only when debounce is compiled in.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port btn, input, 4 bits: raw asynchronous guess buttons.
REQ-008 SHALL have port start, input, 1 bit: synchronous start/restart request, sampled level.
REQ-009 SHALL have ports fsm_win and fsm_lose, input, 1 bit each: status from the guessing FSM.
REQ-010 SHALL have ports fsm_en (output, 1 bit), fsm_rst (output, 1 bit) and fsm_b (output, 4 bits): step enable, reset and guess pattern driven to the FSM.
REQ-011 SHALL have ports level (output, 3 bits), score (output, 8 bits), misses (output, 4 bits), busy (output, 1 bit) and game_over (output, 1 bit).

Function
REQ-012 SHALL implement states IDLE, CLEAR, PLAY, RESULT and OVER.
REQ-013 SHALL handle IDLE as follows: when start=1, go to CLEAR and zero score, misses and level.
REQ-014 SHALL stay in CLEAR exactly one cycle with fsm_rst=1, clear the tick counter and pending guess, then go to PLAY.
REQ-015 SHALL, in PLAY, count tick periods of (TICK_BASE >> level) cycles and pulse fsm_en high for one cycle at the last cycle of each period.
REQ-016 SHALL latch each button press edge into a pending guess, OR-ing multiple presses within one period.
REQ-017 SHALL drive the pending guess on fsm_b only in the fsm_en cycle, drive fsm_b=0 otherwise, and clear the pending guess in the cycle after fsm_en.
REQ-018 SHALL treat a press edge arriving in the fsm_en cycle itself as belonging to the next period.
REQ-019 SHALL, in PLAY, go to RESULT when fsm_win=1 with score+1 (saturating at 255) and level+1 (saturating at 7).
REQ-020 SHALL, in PLAY, go to RESULT when fsm_lose=1 with misses+1; if fsm_win and fsm_lose are both 1, win takes priority.
REQ-021 SHALL, in RESULT, hold fsm_en=0 and fsm_rst=0 for RESULT_HOLD ticks at the current period, counting the period from the RESULT entry cycle.
REQ-022 SHALL leave RESULT for OVER if misses==MAX_MISSES, else for CLEAR.
REQ-023 SHALL, in OVER, set game_over=1 and, on start=1, go to CLEAR and zero score, misses and level.
REQ-024 SHALL drive fsm_rst=1 in IDLE and CLEAR and fsm_rst=0 in every other state.
REQ-025 SHALL drive busy=1 in CLEAR, PLAY and RESULT.
REQ-026 SHALL ignore start while in PLAY or RESULT.

Reset
REQ-027 SHALL, when rst=1 at a clk edge, set state to IDLE from any state, including mid-period or mid-RESULT.
REQ-028 SHALL, on that reset, clear all counters, the pending guess and the synchronizers.
REQ-029 SHALL hold these output values after reset: fsm_en=0, fsm_rst=1, fsm_b=0, level=0, score=0, misses=0, busy=0, game_over=0.

Configuration
REQ-030 SHALL compile per-button debounce in when GUESS_GAME_CTRL_DEBOUNCE_EN is defined: a press edge is declared only after the synchronized bit stays 1 for DEBOUNCE_CYCLES consecutive cycles, and a release likewise.
REQ-031 SHALL, when GUESS_GAME_CTRL_DEBOUNCE_EN is undefined, use only a 2-flop synchronizer plus rising-edge detect, giving a press-to-pending latency of 3 cycles.

Structure
REQ-032 SHALL place the state enum, 4-bit button width and the level/score/misses width constants in shared package guess_pkg.
REQ-033 SHALL instantiate the button path (synchronizer, optional debounce, edge detect) as sub-module btn_sync_edge, 4 bits wide.

Verification (TICK_BASE=128, RESULT_HOLD=2, MAX_MISSES=2, DEBOUNCE_CYCLES=4)
REQ-034 SHALL cover: rst, then start pulse -> fsm_rst high for 1 cycle after IDLE, then fsm_en pulses every 128 cycles, fsm_b=0 with no presses.
REQ-035 SHALL cover: btn=4'b0100 pressed mid-period -> fsm_b=4'b0100 exactly in the next fsm_en cycle and 0 in the following cycle.
REQ-036 SHALL cover: fsm_win asserted in PLAY -> score=1, level=1, RESULT lasts 128 cycles (2 ticks of 64), then CLEAR and fsm_en period 64.
REQ-037 SHALL cover: two fsm_lose events -> misses=2, game_over=1, state OVER; a later start -> score=0, misses=0, level=0, busy=1.
REQ-038 SHALL cover: 8 consecutive wins -> level saturates at 7 with period 1; rst asserted mid-RESULT -> all outputs at reset values on the next cycle.
REQ-039 SHALL cover: with GUESS_GAME_CTRL_DEBOUNCE_EN defined, a 3-cycle btn glitch -> no pending guess; a 6-cycle press -> exactly one pending guess.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared types and widths for the guessing-game controller.
// Used by guess_game_ctrl and btn_sync_edge.
package guess_pkg;

  localparam int BTN_W   = 4;
  localparam int LVL_W   = 3;
  localparam int SCORE_W = 8;
  localparam int MISS_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PLAY,
    RESULT,
    OVER
  } state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Button path: 2-flop synchronizer, optional debounce, rising-edge detect.
// Debounce is compiled in with GUESS_GAME_CTRL_DEBOUNCE_EN.
module btn_sync_edge
  import guess_pkg::*;
#(
  parameter int W               = BTN_W,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q, s2_q;
  logic [W-1:0] lvl;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

`ifdef GUESS_GAME_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [W-1:0] db_q;

  // Each bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar g = 0; g < W; g++) begin : g_db
    logic [DW-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q   <= '0;
        db_q[g] <= 1'b0;
      end else if (s2_q[g] == db_q[g]) begin
        cnt_q   <= '0;
      end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        db_q[g] <= s2_q[g];
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign lvl = db_q;
`else
  assign lvl = s2_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= lvl;
  end

  assign rise_o = lvl & ~prev_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Game sequencer: paces the guessing FSM, latches guesses, keeps score.
// Define GUESS_GAME_CTRL_DEBOUNCE_EN to add per-button debounce.
module guess_game_ctrl
  import guess_pkg::*;
#(
  parameter int TICK_BASE       = 25000000,
  parameter int RESULT_HOLD     = 4,
  parameter int MAX_MISSES      = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BTN_W-1:0]   btn,
  input  logic               start,
  input  logic               fsm_win,
  input  logic               fsm_lose,
  output logic               fsm_en,
  output logic               fsm_rst,
  output logic [BTN_W-1:0]   fsm_b,
  output logic [LVL_W-1:0]   level,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses,
  output logic               busy,
  output logic               game_over
);

  localparam int CW = $clog2(TICK_BASE + 1);
  localparam int HW = $clog2(RESULT_HOLD + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [BTN_W-1:0]   pend_q, pend_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [BTN_W-1:0]   rise;
  logic [CW-1:0]      period;
  logic               tick;

  btn_sync_edge #(
    .W               (BTN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (btn),
    .rise_o (rise)
  );

  assign period = CW'(TICK_BASE >> level_q);
  assign tick   = (cnt_q == period - CW'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    level_d   = level_q;
    score_d   = score_q;
    miss_d    = miss_q;
    fsm_en    = 1'b0;
    fsm_rst   = 1'b0;
    fsm_b     = '0;
    busy      = 1'b0;
    game_over = 1'b0;
    unique case (state_q)
      IDLE: begin
        fsm_rst = 1'b1;
        if (start) begin
          state_d = CLEAR;
          level_d = '0;
          score_d = '0;
          miss_d  = '0;
        end
      end
      CLEAR: begin
        fsm_rst = 1'b1;
        busy    = 1'b1;
        cnt_d   = '0;
        hold_d  = '0;
        pend_d  = '0;
        state_d = PLAY;
      end
      PLAY: begin
        busy   = 1'b1;
        fsm_en = tick;
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        // A press landing in the step cycle starts the next guess.
        fsm_b  = tick ? pend_q : '0;
        pend_d = tick ? rise : (pend_q | rise);
        if (fsm_win) begin
          state_d = RESULT;
          cnt_d   = '0;
          hold_d  = '0;
          if (score_q != '1) score_d = score_q + 1'b1;
          if (level_q != '1) level_d = level_q + 1'b1;
        end else if (fsm_lose) begin
          state_d = RESULT;
          cnt_d   = '0;
          hold_d  = '0;
          miss_d  = miss_q + 1'b1;
        end
      end
      RESULT: begin
        busy  = 1'b1;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          if (hold_q == HW'(RESULT_HOLD - 1)) begin
            if (miss_q == MISS_W'(MAX_MISSES)) state_d = OVER;
            else                               state_d = CLEAR;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      OVER: begin
        game_over = 1'b1;
        if (start) begin
          state_d = CLEAR;
          level_d = '0;
          score_d = '0;
          miss_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      pend_q  <= '0;
      level_q <= '0;
      score_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      level_q <= level_d;
      score_q <= score_d;
      miss_q  <= miss_d;
    end
  end

  assign level  = level_q;
  assign score  = score_q;
  assign misses = miss_q;

endmodule
